// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the attached keyboard: inhibits the clock line,
// issues a request-to-send, shifts out data/parity/stop on device clock
// falling edges, then checks the device ACK and waits for both lines to idle.
// The *_oe outputs only ever pull a line low; the top level turns them into
// open-collector pin drives.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] cmd_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_TX,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Pin conditioning state
    logic clk_meta_reg, clk_sync_reg, clk_prev_reg;
    logic dat_meta_reg, dat_sync_reg;
    logic clk_fe;

    // Transmitter state
    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [9:0]       shift_reg,   shift_next;
    logic [3:0]       bit_idx_reg, bit_idx_next;
    logic             clk_oe_reg,  clk_oe_next;
    logic             dat_oe_reg,  dat_oe_next;
    logic             busy_reg,    busy_next;
    logic             done_reg,    done_next;
    logic             error_reg,   error_next;
    logic             timeout_armed;

    // Two-flop synchronizers plus a history flop for clock falling-edge detect.
    // They reset to 1 (idle bus level) so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_reg <= 1'b1;
            clk_sync_reg <= 1'b1;
            clk_prev_reg <= 1'b1;
            dat_meta_reg <= 1'b1;
            dat_sync_reg <= 1'b1;
        end else begin
            clk_meta_reg <= ps2_clk_in;
            clk_sync_reg <= clk_meta_reg;
            clk_prev_reg <= clk_sync_reg;
            dat_meta_reg <= ps2_dat_in;
            dat_sync_reg <= dat_meta_reg;
        end
    end

    assign clk_fe = clk_prev_reg & ~clk_sync_reg;

    // The watchdog only runs once the clock line has been released.
    assign timeout_armed = (state_reg == S_REQ) || (state_reg == S_TX) ||
                           (state_reg == S_ACK) || (state_reg == S_WAIT_IDLE);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            clk_oe_reg  <= 1'b0;
            dat_oe_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            clk_oe_reg  <= clk_oe_next;
            dat_oe_reg  <= dat_oe_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            error_reg   <= error_next;
        end
    end

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so that every output comes straight from a flop.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        clk_oe_next  = clk_oe_reg;
        dat_oe_next  = dat_oe_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        error_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                busy_next   = 1'b0;
                clk_oe_next = 1'b0;
                dat_oe_next = 1'b0;
                if (send) begin
                    // Frame LSB first: data, odd parity, stop.
                    shift_next  = {1'b1, ~^cmd_byte, cmd_byte};
                    busy_next   = 1'b1;
                    cnt_next    = '0;
                    clk_oe_next = 1'b1;
                    state_next  = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_reg == INHIBIT_LAST) begin
                    // Request-to-send: start bit low, clock released.
                    clk_oe_next = 1'b0;
                    dat_oe_next = 1'b1;
                    cnt_next    = '0;
                    state_next  = S_REQ;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            S_REQ: begin
                cnt_next     = cnt_reg + 1'b1;
                bit_idx_next = '0;
                state_next   = S_TX;
            end

            S_TX: begin
                cnt_next = cnt_reg + 1'b1;
                if (clk_fe) begin
                    dat_oe_next  = ~shift_reg[0];
                    shift_next   = {1'b0, shift_reg[9:1]};
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 4'd9) begin
                        state_next = S_ACK;
                    end
                end
            end

            S_ACK: begin
                cnt_next = cnt_reg + 1'b1;
                if (clk_fe) begin
                    if (!dat_sync_reg) begin
                        state_next = S_WAIT_IDLE;
                    end else begin
                        error_next  = 1'b1;
                        busy_next   = 1'b0;
                        clk_oe_next = 1'b0;
                        dat_oe_next = 1'b0;
                        state_next  = S_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                cnt_next = cnt_reg + 1'b1;
                if (clk_sync_reg && dat_sync_reg) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = S_IDLE;
                end
            end

            default: begin
                busy_next   = 1'b0;
                clk_oe_next = 1'b0;
                dat_oe_next = 1'b0;
                state_next  = S_IDLE;
            end
        endcase

        // Timeout wins over everything, including a simultaneous done.
        if (timeout_armed && (cnt_reg == TIMEOUT_LAST)) begin
            error_next  = 1'b1;
            done_next   = 1'b0;
            busy_next   = 1'b0;
            clk_oe_next = 1'b0;
            dat_oe_next = 1'b0;
            state_next  = S_IDLE;
        end
    end

    assign ps2_clk_oe = clk_oe_reg;
    assign ps2_dat_oe = dat_oe_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign error      = error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard model drives the PS/2 clock,
// samples the bus on its rising edges and optionally ACKs; results are
// compared against values derived from the command byte.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 50;
    localparam int TIMEOUT = 20000;

    logic       clk;
    logic       reset;
    logic       send;
    logic [7:0] cmd_byte;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;

    // Device side of the open-collector bus
    logic dev_clk_low;
    logic dev_dat_low;

    int checks;
    int errors;
    int done_cnt;
    int err_cnt;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .send(send),
        .cmd_byte(cmd_byte),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy(busy),
        .done(done),
        .error(error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Count done/error pulses (in cycles high) and check their invariants.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                done_cnt++;
                check("busy_with_done", 32'(busy), 32'd0);
            end
            if (error) err_cnt++;
            if (done || error) check("done_err_excl", 32'(done & error), 32'd0);
        end
    end

    // Device clocks n bits, sampling the bus on each rising edge.
    task automatic dev_clock_bits(input int n, input int h, output logic [9:0] bits);
        bits = '0;
        for (int k = 0; k < n; k++) begin
            dev_clk_low = 1'b1;
            repeat (h) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[k] = ps2_dat_in;
            repeat (h) @(negedge clk);
        end
    endtask

    // Wait for the request-to-send (clock released); returns cycles waited.
    task automatic wait_req(output int n);
        n = 0;
        while (ps2_clk_oe && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_frame(input logic [7:0] b, input bit ack, input bit resend, input int h);
        int n;
        int d0;
        int e0;
        logic [9:0] bits;
        logic exp_par;
        d0 = done_cnt;
        e0 = err_cnt;
        exp_par = (($countones(b) % 2) == 0);
        @(negedge clk);
        send = 1'b1;
        cmd_byte = b;
        @(negedge clk);
        send = 1'b0;
        cmd_byte = 8'($urandom);
        check("busy_set", 32'(busy), 32'd1);
        n = 0;
        while (ps2_clk_oe && n < 1000) begin
            n++;
            if (resend && n == 10) begin
                send = 1'b1;
                cmd_byte = ~b;
            end else begin
                send = 1'b0;
            end
            @(negedge clk);
        end
        send = 1'b0;
        check("inhibit_len", 32'(n), 32'(INHIBIT));
        check("start_bit", 32'(ps2_dat_oe), 32'd1);
        repeat (5) @(negedge clk);
        dev_clock_bits(10, h, bits);
        check("data_bits", 32'(bits[7:0]), 32'(b));
        check("parity", 32'(bits[8]), 32'(exp_par));
        check("stop", 32'(bits[9]), 32'd1);
        // 11th clock: ACK by holding data low, or leave it released.
        if (ack) dev_dat_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (h) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_dat_low = 1'b0;
        repeat (20) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        check("error_pulses", 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
        check("clk_released", 32'(ps2_clk_oe), 32'd0);
        check("dat_released", 32'(ps2_dat_oe), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
        $display("frame byte=%02h ack=%0d resend=%0d half=%0d sampled=%02h par=%0d stop=%0d",
                 b, ack, resend, h, bits[7:0], bits[8], bits[9]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int e0;
        logic [9:0] bits;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        err_cnt = 0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        reset = 1'b1;
        send = 1'b0;
        cmd_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        do_frame(8'hED, 1'b1, 1'b0, 20);
        do_frame(8'h00, 1'b1, 1'b0, 20);
        do_frame(8'h01, 1'b1, 1'b0, 20);
        do_frame(8'($urandom), 1'b0, 1'b0, 20);
        do_frame(8'($urandom), 1'b1, 1'b1, 20);
        for (int i = 0; i < 4; i++) begin
            do_frame(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, int'($urandom_range(12, 30)));
        end

        // Reset in the middle of transmission, just after the 4th falling edge
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        send = 1'b1;
        cmd_byte = 8'h5A;
        @(negedge clk);
        send = 1'b0;
        wait_req(n);
        repeat (5) @(negedge clk);
        dev_clock_bits(3, 20, bits);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_no_error", 32'(err_cnt - e0), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        $display("reset mid-frame after fe4: lines released");

        // Device never clocks: timeout measured from the request-to-send
        @(negedge clk);
        send = 1'b1;
        cmd_byte = 8'hFF;
        @(negedge clk);
        send = 1'b0;
        wait_req(n);
        check("to_req_seen", 32'(ps2_clk_oe), 32'd0);
        n = 0;
        while (!error && n < TIMEOUT + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_len", 32'(n), 32'(TIMEOUT));
        check("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("to_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("to_error_1cyc", 32'(error), 32'd0);
        $display("timeout after %0d cycles", n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
